enokida_line_fill: RTL

Line-refill engine between the Enokida direct-mapped cache miss path and the AXI4 memory slave (instruction or data side). On a miss it accepts one line address, issues a single aligned AXI4 INCR read burst, and streams each returned word back to the cache with its word index. It flags protocol or response errors and keeps a saturating count of completed fills for the hit/miss statistics gathered by the Kuuga benches.

---
 rtl/enokida_cache_pkg.sv | 28 ++
 rtl/enokida_line_fill.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/enokida_cache_pkg.sv
// rtl/enokida_cache_pkg.sv - shared types and AXI constants for the Enokida cache refill path
//
// Purpose: fill engine state encoding, AXI4 burst/size/response codes, and the
// line-base address helper used when a miss request is latched.
// Ports: none (package).

package enokida_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } fill_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Clears the byte-in-line offset so the burst starts on a line boundary.
    // Works on a 64-bit container; callers keep the low ADDR_WIDTH bits.
    function automatic logic [63:0] line_base(input logic [63:0] addr,
                                              input int unsigned off_bits);
        return addr & ~((64'd1 << off_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/enokida_line_fill.sv
// rtl/enokida_line_fill.sv - cache line refill engine issuing one AXI4 INCR read burst per miss
//
// Purpose: accepts a miss address, reads one aligned line over AXI4, streams the
// returned words with their in-line index, flags corrupt lines and counts good fills.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   miss request handshake
//   word_valid/word_idx/word_data  returned word stream (registered)
//   fill_done/fill_err             line complete pulse, corrupt qualifier
//   fill_count                     saturating count of error-free fills
//   m_axi_ar*                      AXI4 read address channel
//   m_axi_r*                       AXI4 read data channel

module enokida_line_fill
    import enokida_cache_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [3:0]  AXI_ID         = 4'd0,
    localparam int         IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,

    output logic                  word_valid,
    output logic [IDX_W-1:0]      word_idx,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  fill_done,
    output logic                  fill_err,
    output logic [31:0]           fill_count,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arid,

    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic [3:0]            m_axi_rid
);

    localparam int unsigned       OFF_BITS  = IDX_W + 2;
    localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    fill_state_t      state;
    logic [IDX_W-1:0] beat;
    logic             err_flag;
    logic [63:0]      base_full;
    logic             beat_fire;
    logic             last_beat;
    logic             line_err;

    assign base_full = line_base(64'(req_addr), OFF_BITS);

    generate
        if (ADDR_WIDTH < 64) begin : g_base_hi
            logic unused_base_hi;
            assign unused_base_hi = |base_full[63:ADDR_WIDTH];
        end
    endgenerate

    // AR fields other than the address never change, so they are constants.
    assign m_axi_arlen   = 8'(WORDS_PER_LINE - 1);
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arid    = AXI_ID;

    // Handshake strobes decode state only, so they cannot glitch on inputs.
    assign m_axi_arvalid = (state == ST_ADDR);
    assign m_axi_rready  = (state == ST_DATA) || (state == ST_DRAIN);

    assign beat_fire = m_axi_rvalid && m_axi_rready;
    assign last_beat = (beat == LAST_BEAT);

    // rlast must coincide exactly with the final beat; any mismatch (early or
    // missing) marks the line corrupt, as do bad responses and foreign IDs.
    assign line_err = err_flag
                   || (m_axi_rresp != RESP_OKAY)
                   || (m_axi_rid != AXI_ID)
                   || (m_axi_rlast != last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            m_axi_araddr <= '0;
            beat         <= '0;
            err_flag     <= 1'b0;
            word_valid   <= 1'b0;
            word_idx     <= '0;
            word_data    <= '0;
            fill_done    <= 1'b0;
            fill_err     <= 1'b0;
            fill_count   <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            fill_done  <= 1'b0;
            fill_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // req_ready is held low for the first IDLE cycle after a
                    // fill so it rises the cycle after fill_done.
                    if (req_ready && req_valid) begin
                        m_axi_araddr <= base_full[ADDR_WIDTH-1:0];
                        beat         <= '0;
                        err_flag     <= 1'b0;
                        req_ready    <= 1'b0;
                        state        <= ST_ADDR;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (m_axi_arready) begin
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (beat_fire) begin
                        word_valid <= 1'b1;
                        word_data  <= m_axi_rdata;
                        word_idx   <= beat;
                        beat       <= beat + 1'b1;
                        if (m_axi_rlast) begin
                            // Normal or early end: close the line on this beat.
                            fill_done <= 1'b1;
                            fill_err  <= line_err;
                            state     <= ST_IDLE;
                            if (!line_err && (fill_count != 32'hFFFF_FFFF)) begin
                                fill_count <= fill_count + 32'd1;
                            end
                        end else if (last_beat) begin
                            // Slave overran the line; swallow beats until rlast.
                            err_flag <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            err_flag <= line_err;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (beat_fire && m_axi_rlast) begin
                        fill_done <= 1'b1;
                        fill_err  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
